// File: rtl/jtframe_debug_keys_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jtframe_debug_keys_pkg
// Description : Shared scan-code constants, prefix FSM encoding and key-mask
//               helpers for the PS/2 debug-key decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package jtframe_debug_keys_pkg;

    // Scan-code prefixes
    localparam logic [7:0] c_PFX_EXT   = 8'hE0;
    localparam logic [7:0] c_PFX_BRK   = 8'hF0;
    localparam logic [7:0] c_PFX_PAUSE = 8'hE1;

    // Mapped make codes (normal set unless noted)
    localparam logic [7:0] c_LSHIFT   = 8'h12;
    localparam logic [7:0] c_RSHIFT   = 8'h59;
    localparam logic [7:0] c_CTRL     = 8'h14;  // left ctrl, or right ctrl after E0
    localparam logic [7:0] c_KP_PLUS  = 8'h79;
    localparam logic [7:0] c_KP_MINUS = 8'h7B;
    localparam logic [7:0] c_F1       = 8'h05;
    localparam logic [7:0] c_F2       = 8'h06;
    localparam logic [7:0] c_F3       = 8'h04;
    localparam logic [7:0] c_F4       = 8'h0C;
    localparam logic [7:0] c_D1       = 8'h16;
    localparam logic [7:0] c_D2       = 8'h1E;
    localparam logic [7:0] c_D3       = 8'h26;
    localparam logic [7:0] c_D4       = 8'h25;
    localparam logic [7:0] c_D5       = 8'h2E;
    localparam logic [7:0] c_D6       = 8'h36;
    localparam logic [7:0] c_D7       = 8'h3D;
    localparam logic [7:0] c_D8       = 8'h3E;

    // Keyboard status/protocol bytes that never carry key information
    localparam logic [7:0] c_ACK    = 8'hFA;
    localparam logic [7:0] c_BAT_OK = 8'hAA;
    localparam logic [7:0] c_ECHO   = 8'hEE;
    localparam logic [7:0] c_RESEND = 8'hFE;
    localparam logic [7:0] c_ERR    = 8'h00;

    // Bytes following E1 that belong to the Pause sequence
    localparam logic [2:0] c_PAUSE_LEN = 3'd7;

    // Prefix FSM encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EXT    = 3'd1,
        ST_BRK    = 3'd2,
        ST_EXTBRK = 3'd3,
        ST_SKIP   = 3'd4
    } state_t;

    // One-hot position of a function key in key_gfx (F1 is bit 0)
    function automatic logic [3:0] gfx_mask(input logic [7:0] code);
        case (code)
            c_F1:    gfx_mask = 4'b0001;
            c_F2:    gfx_mask = 4'b0010;
            c_F3:    gfx_mask = 4'b0100;
            c_F4:    gfx_mask = 4'b1000;
            default: gfx_mask = 4'b0000;
        endcase
    endfunction

    // One-hot position of a digit key in key_digit (key 1 is bit 0)
    function automatic logic [7:0] digit_mask(input logic [7:0] code);
        case (code)
            c_D1:    digit_mask = 8'h01;
            c_D2:    digit_mask = 8'h02;
            c_D3:    digit_mask = 8'h04;
            c_D4:    digit_mask = 8'h08;
            c_D5:    digit_mask = 8'h10;
            c_D6:    digit_mask = 8'h20;
            c_D7:    digit_mask = 8'h40;
            c_D8:    digit_mask = 8'h80;
            default: digit_mask = 8'h00;
        endcase
    endfunction

    // Status bytes swallowed while waiting for a new key sequence
    function automatic logic is_status_byte(input logic [7:0] code);
        is_status_byte = (code == c_ACK)    || (code == c_BAT_OK) ||
                         (code == c_ECHO)   || (code == c_RESEND) ||
                         (code == c_ERR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtframe_debug_keys_if.sv
`default_nettype none
// ============================================================================
// Module      : jtframe_debug_keys_if
// Description : Byte stream from the PS/2 receiver into the debug-key decoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface jtframe_debug_keys_if;
    import jtframe_debug_keys_pkg::*;

    logic       ps2_valid;  // one-cycle strobe, ps2_byte is new
    logic [7:0] ps2_byte;

    modport master (output ps2_valid, output ps2_byte);
    modport slave  (input  ps2_valid, input  ps2_byte);
endinterface
`default_nettype wire

// File: rtl/jtframe_debug_repeat.sv
`default_nettype none
// ============================================================================
// Module      : jtframe_debug_repeat
// Description : Hold-to-repeat shaper for one key. Passes the held level
//               through, but after REPEAT_DLY held cycles drops it for one
//               cycle, then again every REPEAT_PER cycles while still held.
// Revision    : 1.0 - initial release
// ============================================================================
module jtframe_debug_repeat
    import jtframe_debug_keys_pkg::*;
#(
    parameter logic [23:0] REPEAT_DLY = 24'd12_000_000,
    parameter logic [23:0] REPEAT_PER = 24'd2_400_000
)(
    input  logic clk,
    input  logic rst,
    input  logic i_held,
    output logic o_level
);

    // r_cnt counts held cycles: from the first held cycle (value 0) until
    // the initial drop, then cycles since the previous drop.
    logic [23:0] r_cnt;
    logic        r_rep;     // initial delay already elapsed
    logic        w_drop;

    assign w_drop  = i_held & (r_rep ? (r_cnt == REPEAT_PER)
                                     : (r_cnt == REPEAT_DLY));
    // A break leaves the level low regardless of the drop phase
    assign o_level = i_held & ~w_drop;

    // Hold timer: cleared whenever the key is released, so each new make
    // starts the delay from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 24'd0;
            r_rep <= 1'b0;
        end else if (!i_held) begin
            r_cnt <= 24'd0;
            r_rep <= 1'b0;
        end else if (w_drop) begin
            r_cnt <= 24'd1;
            r_rep <= 1'b1;
        end else begin
            r_cnt <= r_cnt + 24'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/jtframe_debug_keys.sv
`default_nettype none
// ============================================================================
// Module      : jtframe_debug_keys
// Description : PS/2 set-2 scan-code decoder producing held-key levels for
//               the debug overlay (shift, ctrl, keypad +/-, F1-F4, digits
//               1-8). Tracks E0/F0 prefixes and swallows the E1 Pause
//               sequence.
//               Optional macro JTFRAME_DEBUG_REPEAT_EN adds hold-to-repeat
//               shaping on debug_plus / debug_minus.
// Revision    : 1.0 - initial release
// ============================================================================
module jtframe_debug_keys
    import jtframe_debug_keys_pkg::*;
#(
    parameter logic [23:0] REPEAT_DLY = 24'd12_000_000,
    parameter logic [23:0] REPEAT_PER = 24'd2_400_000
)(
    input  logic                       clk,
    input  logic                       rst,
    jtframe_debug_keys_if.slave        ps2,
    output logic                       shift,
    output logic                       ctrl,
    output logic                       debug_plus,
    output logic                       debug_minus,
    output logic [3:0]                 key_gfx,
    output logic [7:0]                 key_digit
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_skip_cnt;
    logic [2:0]  w_skip_nxt;

    logic        w_make;    // current byte completes a make sequence
    logic        w_brk;     // current byte completes a break sequence
    logic        w_ext;     // ... and it belongs to the E0 extended set
    logic [7:0]  w_code;

    logic        r_lshift, r_rshift;
    logic        r_lctrl,  r_rctrl;
    logic        r_plus,   r_minus;
    logic [3:0]  r_gfx;
    logic [7:0]  r_digit;

    assign w_code = ps2.ps2_byte;

    // Prefix FSM state and Pause-skip counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_skip_cnt <= 3'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_skip_cnt <= w_skip_nxt;
        end
    end

    // Prefix FSM next state and sequence-completion decode
    always_comb begin
        w_state_nxt = r_state;
        w_skip_nxt  = r_skip_cnt;
        w_make      = 1'b0;
        w_brk       = 1'b0;
        w_ext       = 1'b0;
        if (ps2.ps2_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_code == c_PFX_EXT) begin
                        w_state_nxt = ST_EXT;
                    end else if (w_code == c_PFX_BRK) begin
                        w_state_nxt = ST_BRK;
                    end else if (w_code == c_PFX_PAUSE) begin
                        w_state_nxt = ST_SKIP;
                        w_skip_nxt  = c_PAUSE_LEN;
                    end else if (!is_status_byte(w_code)) begin
                        w_make = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (w_code == c_PFX_BRK) begin
                        w_state_nxt = ST_EXTBRK;
                    end else begin
                        w_make      = 1'b1;
                        w_ext       = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    w_brk       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
                ST_EXTBRK: begin
                    w_brk       = 1'b1;
                    w_ext       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
                ST_SKIP: begin
                    // Leave on the byte that brings the count to zero
                    if (r_skip_cnt <= 3'd1) begin
                        w_skip_nxt  = 3'd0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_skip_nxt  = r_skip_cnt - 3'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_skip_nxt  = 3'd0;
                end
            endcase
        end
    end

    // Held-key flags: a make sets, a break clears; repeated makes are no-ops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lshift <= 1'b0;
            r_rshift <= 1'b0;
            r_lctrl  <= 1'b0;
            r_rctrl  <= 1'b0;
            r_plus   <= 1'b0;
            r_minus  <= 1'b0;
            r_gfx    <= 4'd0;
            r_digit  <= 8'd0;
        end else if (w_make || w_brk) begin
            if (w_ext) begin
                // Right ctrl is the only extended key of interest
                if (w_code == c_CTRL) r_rctrl <= w_make;
            end else begin
                if (w_code == c_LSHIFT)   r_lshift <= w_make;
                if (w_code == c_RSHIFT)   r_rshift <= w_make;
                if (w_code == c_CTRL)     r_lctrl  <= w_make;
                if (w_code == c_KP_PLUS)  r_plus   <= w_make;
                if (w_code == c_KP_MINUS) r_minus  <= w_make;
                r_gfx   <= w_make ? (r_gfx   |  gfx_mask(w_code))
                                  : (r_gfx   & ~gfx_mask(w_code));
                r_digit <= w_make ? (r_digit |  digit_mask(w_code))
                                  : (r_digit & ~digit_mask(w_code));
            end
        end
    end

    // Outputs are pure functions of the flag registers (no input paths)
    assign shift     = r_lshift | r_rshift;
    assign ctrl      = r_lctrl  | r_rctrl;
    assign key_gfx   = r_gfx;
    assign key_digit = r_digit;

`ifdef JTFRAME_DEBUG_REPEAT_EN
    jtframe_debug_repeat #(
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_PER (REPEAT_PER)
    ) u_rep_plus (
        .clk        (clk),
        .rst        (rst),
        .i_held     (r_plus),
        .o_level    (debug_plus)
    );

    jtframe_debug_repeat #(
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_PER (REPEAT_PER)
    ) u_rep_minus (
        .clk        (clk),
        .rst        (rst),
        .i_held     (r_minus),
        .o_level    (debug_minus)
    );
`else
    assign debug_plus  = r_plus;
    assign debug_minus = r_minus;

    // Repeat timing is meaningless without the shaper
    logic w_unused_cfg;
    assign w_unused_cfg = ^{REPEAT_DLY, REPEAT_PER};
`endif

endmodule
`default_nettype wire

// File: doc/jtframe_debug_keys.md
# jtframe_debug_keys

PS/2 set-2 scan-code decoder that turns a keyboard byte stream into the held-key levels consumed by the debug overlay/control stage (`shift`, `ctrl`, `debug_plus`, `debug_minus`, `key_gfx`, `key_digit`). It sits between the PS/2 byte receiver and the debug stage. It tracks make/break prefixes and extended codes, and keeps one held-state flag per relevant key. The downstream stage edge-detects every output, so outputs are levels, not pulses.

## Interface
- `REPEAT_DLY`, 24'd12_000_000, cycles a +/- key must be held before auto-repeat starts (only with the repeat macro).
- `REPEAT_PER`, 24'd2_400_000, cycles between auto-repeat events (only with the repeat macro).
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `ps2_valid`  in  1  one-cycle strobe: `ps2_byte` holds a new received byte.
- `ps2_byte`  in  8  received scan-code byte.
- `shift`  out  1  left (0x12) or right (0x59) shift held.
- `ctrl`  out  1  left (0x14) or right (E0 14) ctrl held.
- `debug_plus`  out  1  keypad + (0x79) held.
- `debug_minus`  out  1  keypad − (0x7B) held.
- `key_gfx`  out  4  F1 (0x05), F2 (0x06), F3 (0x04), F4 (0x0C) held; bit 0 is F1.
- `key_digit`  out  8  digit keys 1–8 held (0x16, 0x1E, 0x26, 0x25, 0x2E, 0x36, 0x3D, 0x3E); bit 0 is key 1.

## Operation
- Prefix FSM, advanced only on `ps2_valid`:
  - IDLE: E0 → EXT; F0 → BRK; E1 → SKIP with `skip_cnt`=7; any other byte is a make code in the normal set → IDLE.
  - EXT: F0 → EXTBRK; any other byte is a make code in the extended set → IDLE.
  - BRK: byte is a break code in the normal set → IDLE.
  - EXTBRK: byte is a break code in the extended set → IDLE.
  - SKIP: decrement `skip_cnt` on each byte; go to IDLE after the byte that takes it to 0. This swallows the 8-byte Pause sequence.
- Make code sets the matching flag; break code clears it. Unmapped codes change no flag but still complete the sequence.
- Extended set maps only E0 14 (right ctrl); every other extended code is ignored.
- Left/right shift and left/right ctrl have separate internal flags. `shift` and `ctrl` are the OR of each pair.
- A make for a key already held (typematic) is idempotent.
- Byte values FA, AA, EE, FE and 00 in IDLE are ignored; the FSM stays in IDLE.
- Reset: all flags 0, FSM IDLE, `skip_cnt` 0, repeat counters 0. Every output resets to 0.

## Timing
- All outputs are registered. A flag change is visible on the cycle after the `ps2_valid` cycle (latency 1).
- Only the byte presented with `ps2_valid` high is sampled.
- Back-to-back `ps2_valid` on consecutive cycles is supported; each byte advances the FSM once.
- An asserted `rst` takes effect immediately, including mid-sequence (after E0 or F0). The first byte after reset is decoded from IDLE.

## Configuration
- `JTFRAME_DEBUG_REPEAT_EN` defined:
  - While `debug_plus` (or `debug_minus`) is held continuously for `REPEAT_DLY` cycles, the output drops to 0 for exactly one cycle.
  - It then repeats the one-cycle drop every `REPEAT_PER` cycles while the key is held.
  - Each key has its own 24-bit counter, cleared on make and on break.
  - A break during a drop cycle leaves the output at 0.
- Not defined: outputs follow the flags exactly; no counters are instantiated.

## Structure
- Shared package `jtframe_debug_keys_pkg`:
  - scan-code localparams (prefixes E0/F0/E1 and all mapped codes);
  - FSM state encoding (IDLE, EXT, BRK, EXTBRK, SKIP, 3 bits).
- One sub-module: `jtframe_debug_repeat`.
  - Per-key hold-to-repeat timer; input: held level; output: repeat-shaped level.
  - Instantiated twice, only under the macro.

## Test plan
- Send 79, then F0 79 → `debug_plus` goes 1 one cycle after 79 and back to 0 one cycle after the second byte; all other outputs stay 0.
- Send 12, 59, F0 12 → `shift`=1 after 12 and remains 1 after F0 12; send F0 59 → `shift`=0.
- Send E0 14 then 14, then E0 F0 14 → `ctrl` stays 1; then F0 14 → `ctrl`=0. Send E0 79 → `debug_plus` stays 0.
- Send E1 14 77 E1 F0 14 F0 77, then 16 → only `key_digit`=8'h01 asserts. Send 06 → `key_gfx`=4'b0010.
- Assert `rst` right after an F0 byte, release it, then send 05 → `key_gfx`=4'b0001 (05 is treated as a make, not a break).
- With `JTFRAME_DEBUG_REPEAT_EN`, `REPEAT_DLY`=10, `REPEAT_PER`=4, hold 7B for 30 cycles → `debug_minus` drops for one cycle at hold cycles 10, 14, 18, 22, 26.
